reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/bit_synchronizer.sv | 23 ++
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and default parameters for the reset sequencer.
// Holds the FSM state encoding, the default build parameters and a small
// helper that sizes the shared cycle counter.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT_ALL = 2'd0,
    WAIT_ACK   = 2'd1,
    GAP        = 2'd2,
    DONE       = 2'd3
  } reset_seq_state_t;

  localparam int unsigned DEFAULT_NUM_DOMAINS    = 4;
  localparam int unsigned DEFAULT_HOLD_CYCLES    = 16;
  localparam int unsigned DEFAULT_GAP_CYCLES     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  // Largest of three cycle counts; used to size the shared counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for one asynchronous bit into the clk domain.
// Ports: clk - destination clock; rst_n - async active-low clear of both
// flops; d - asynchronous input; q - synchronized output.
module bit_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer.
// Holds every downstream domain in reset for HOLD_CYCLES, then releases the
// domains one at a time (domain 0 first), waiting for each domain's
// acknowledge (or a timeout) and GAP_CYCLES idle cycles before the next.
// Ports:
//   sync_clk       - single clock
//   reset_async_n  - asynchronous active-low reset of the sequencer
//   soft_reset_req - level request to restart the whole sequence
//   reset_out      - active-high reset per domain (registered)
//   ack_in         - asynchronous per-domain "out of reset" acknowledge
//   ready          - all domains released (registered)
//   timeout_err    - sticky per-domain acknowledge timeout (registered)
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = DEFAULT_NUM_DOMAINS,
  parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   sync_clk,
  input  logic                   reset_async_n,
  input  logic                   soft_reset_req,
  output logic [NUM_DOMAINS-1:0] reset_out,
  input  logic [NUM_DOMAINS-1:0] ack_in,
  output logic                   ready,
  output logic [NUM_DOMAINS-1:0] timeout_err
);

  localparam int unsigned CNT_MAX = max3(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef logic [CNT_W-1:0]       cnt_t;
  typedef logic [IDX_W-1:0]       idx_t;
  typedef logic [NUM_DOMAINS-1:0] dom_t;

  // Terminal counts: the counter runs up from 0 and the phase ends on the
  // cycle it reaches N-1, so each phase lasts exactly N cycles.
  localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t GAP_LAST  = cnt_t'(GAP_CYCLES - 1);
  localparam cnt_t TO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam idx_t LAST_IDX  = idx_t'(NUM_DOMAINS - 1);

  reset_seq_state_t state_q, state_d;
  idx_t             idx_q, idx_d, idx_nxt;
  cnt_t             cnt_q, cnt_d;
  dom_t             reset_out_d;
  logic             ready_d;
  dom_t             timeout_err_d;
  dom_t             ack_sync;
  logic             ack_cur;

  // Per-domain acknowledge synchronizers.
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_ack_sync
    bit_synchronizer u_sync (
      .clk   (sync_clk),
      .rst_n (reset_async_n),
      .d     (ack_in[i]),
      .q     (ack_sync[i])
    );
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge sync_clk or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state_q     <= ASSERT_ALL;
      idx_q       <= '0;
      cnt_q       <= '0;
      reset_out   <= '1;
      ready       <= 1'b0;
      timeout_err <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      reset_out   <= reset_out_d;
      ready       <= ready_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    reset_out_d   = reset_out;
    ready_d       = ready;
    timeout_err_d = timeout_err;
    idx_nxt       = idx_q + idx_t'(1);
    ack_cur       = ack_sync[idx_q];

    if (soft_reset_req) begin
      // Restart from any state; the counter stays reloaded while held.
      state_d       = ASSERT_ALL;
      idx_d         = '0;
      cnt_d         = '0;
      reset_out_d   = '1;
      ready_d       = 1'b0;
      timeout_err_d = '0;
    end else begin
      unique case (state_q)
        ASSERT_ALL: begin
          if (cnt_q == HOLD_LAST) begin
            state_d     = WAIT_ACK;
            idx_d       = '0;
            cnt_d       = '0;
            reset_out_d = ~dom_t'(1);
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        WAIT_ACK: begin
          if (ack_cur || (cnt_q == TO_LAST)) begin
            // Acknowledge wins over a timeout landing on the same cycle.
            if (!ack_cur) begin
              timeout_err_d = timeout_err | (dom_t'(1) << idx_q);
            end
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_nxt;
              if (GAP_CYCLES == 0) begin
                state_d     = WAIT_ACK;
                reset_out_d = reset_out & ~(dom_t'(1) << idx_nxt);
              end else begin
                state_d = GAP;
              end
            end
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d     = WAIT_ACK;
            cnt_d       = '0;
            reset_out_d = reset_out & ~(dom_t'(1) << idx_q);
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        DONE: begin
          ready_d = 1'b1;
        end

        default: begin
          state_d = ASSERT_ALL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: table-driven release timelines plus
// hand-written sequences for soft restart, async abort and timeout recovery.
module tb_reset_sequencer;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  rst;
    logic        rdy;
    logic [3:0]  terr;
  } vec_t;

  logic       sync_clk = 1'b0;
  logic       reset_async_n;
  logic       soft_reset_req;
  logic [3:0] reset_out, ack_in, timeout_err;
  logic       ready;
  logic [3:0] reset_out0, ack_in0, timeout_err0;
  logic       ready0;
  logic [3:0] ack_mask, ack_force;

  int unsigned edge_n;
  int          n_checks;
  int          n_fail;
  vec_t        vecs[$];

  always #5 sync_clk = ~sync_clk;

  // Domains acknowledge as soon as their reset drops, unless masked/forced.
  assign ack_in  = (~reset_out & ~ack_mask) | ack_force;
  assign ack_in0 = ~reset_out0;

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(32)
  ) dut (
    .sync_clk       (sync_clk),
    .reset_async_n  (reset_async_n),
    .soft_reset_req (soft_reset_req),
    .reset_out      (reset_out),
    .ack_in         (ack_in),
    .ready          (ready),
    .timeout_err    (timeout_err)
  );

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .GAP_CYCLES(0), .TIMEOUT_CYCLES(32)
  ) dut_gap0 (
    .sync_clk       (sync_clk),
    .reset_async_n  (reset_async_n),
    .soft_reset_req (soft_reset_req),
    .reset_out      (reset_out0),
    .ack_in         (ack_in0),
    .ready          (ready0),
    .timeout_err    (timeout_err0)
  );

  function automatic vec_t mk(input int unsigned e, input logic [3:0] r,
                              input logic rd, input logic [3:0] t);
    vec_t v;
    v.edge_n = e;
    v.rst    = r;
    v.rdy    = rd;
    v.terr   = t;
    return v;
  endfunction

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h, expected %h", nm, edge_n, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] r, input logic rd,
                           input logic [3:0] t);
    check4({tag, " reset_out"}, reset_out, r);
    check4({tag, " ready"}, {3'b000, ready}, {3'b000, rd});
    check4({tag, " timeout_err"}, timeout_err, t);
  endtask

  // Hold reset low for a few cycles, release between edges; edge 1 follows.
  task automatic apply_reset();
    reset_async_n  = 1'b0;
    soft_reset_req = 1'b0;
    repeat (3) @(negedge sync_clk);
    reset_async_n = 1'b1;
    edge_n        = 0;
  endtask

  // Advance to just after the given edge (counted from reset release).
  task automatic step_to(input int unsigned n);
    while (edge_n < n) begin
      @(posedge sync_clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic run_table(input string tag, input bit use_gap0);
    foreach (vecs[k]) begin
      step_to(vecs[k].edge_n);
      if (use_gap0) begin
        check4({tag, " reset_out"}, reset_out0, vecs[k].rst);
        check4({tag, " ready"}, {3'b000, ready0}, {3'b000, vecs[k].rdy});
        check4({tag, " timeout_err"}, timeout_err0, vecs[k].terr);
      end else begin
        check_all(tag, vecs[k].rst, vecs[k].rdy, vecs[k].terr);
      end
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    edge_n         = 0;
    ack_mask       = 4'b0000;
    ack_force      = 4'b0000;
    soft_reset_req = 1'b0;
    reset_async_n  = 1'b0;

    // Reset state while reset is held.
    #12;
    check_all("in_reset", 4'hF, 1'b0, 4'h0);
    check4("in_reset gap0 reset_out", reset_out0, 4'hF);

    // Nominal release timeline.
    apply_reset();
    vecs.delete();
    vecs.push_back(mk(0,  4'hF, 1'b0, 4'h0));
    vecs.push_back(mk(15, 4'hF, 1'b0, 4'h0));
    vecs.push_back(mk(16, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(22, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(23, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(29, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(30, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(36, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(37, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(39, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(40, 4'h0, 1'b1, 4'h0));
    vecs.push_back(mk(45, 4'h0, 1'b1, 4'h0));
    run_table("nominal", 1'b0);

    // Async reset from DONE clears ready without a clock edge.
    #2 reset_async_n = 1'b0;
    #1 check_all("abort_done", 4'hF, 1'b0, 4'h0);

    // Zero-gap build: releases 3 edges apart.
    apply_reset();
    vecs.delete();
    vecs.push_back(mk(0,  4'hF, 1'b0, 4'h0));
    vecs.push_back(mk(15, 4'hF, 1'b0, 4'h0));
    vecs.push_back(mk(16, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(18, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(19, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(21, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(22, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(24, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(25, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(27, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(28, 4'h0, 1'b1, 4'h0));
    run_table("gap0", 1'b1);

    // Soft restart pulse between edges 25 and 26.
    apply_reset();
    step_to(25);
    check_all("soft_pre", 4'hC, 1'b0, 4'h0);
    soft_reset_req = 1'b1;
    step_to(26);
    check_all("soft_hit", 4'hF, 1'b0, 4'h0);
    soft_reset_req = 1'b0;
    step_to(41);
    check4("soft_hold reset_out", reset_out, 4'hF);
    step_to(42);
    check4("soft_rel0 reset_out", reset_out, 4'hE);
    step_to(49);
    check4("soft_rel1 reset_out", reset_out, 4'hC);
    step_to(65);
    check4("soft_notready", {3'b000, ready}, 4'h0);
    step_to(66);
    check4("soft_ready", {3'b000, ready}, 4'h1);

    // Async abort mid-GAP, then full restart.
    apply_reset();
    step_to(21);
    check4("gap_pre reset_out", reset_out, 4'hE);
    #2 reset_async_n = 1'b0;
    #1 check_all("abort_gap", 4'hF, 1'b0, 4'h0);
    apply_reset();
    step_to(15);
    check4("abort_hold reset_out", reset_out, 4'hF);
    step_to(16);
    check4("abort_rel0 reset_out", reset_out, 4'hE);
    step_to(23);
    check4("abort_rel1 reset_out", reset_out, 4'hC);

    // Domain 2 never acknowledges: timeout, then continue.
    ack_mask = 4'b0100;
    apply_reset();
    vecs.delete();
    vecs.push_back(mk(16, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(23, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(30, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(61, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(62, 4'h8, 1'b0, 4'h4));
    vecs.push_back(mk(65, 4'h8, 1'b0, 4'h4));
    vecs.push_back(mk(66, 4'h0, 1'b0, 4'h4));
    vecs.push_back(mk(68, 4'h0, 1'b0, 4'h4));
    vecs.push_back(mk(69, 4'h0, 1'b1, 4'h4));
    run_table("timeout", 1'b0);

    // Soft request from DONE clears the sticky error; held high delays HOLD.
    soft_reset_req = 1'b1;
    step_to(70);
    check_all("soft_done", 4'hF, 1'b0, 4'h0);
    step_to(72);
    soft_reset_req = 1'b0;
    step_to(87);
    check4("soft_held reset_out", reset_out, 4'hF);
    step_to(88);
    check4("soft_held_rel reset_out", reset_out, 4'hE);
    ack_mask = 4'b0000;

    // Domain 1 acknowledge stuck high: early ack ignored, accepted at release.
    ack_force = 4'b0010;
    apply_reset();
    vecs.delete();
    vecs.push_back(mk(16, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(22, 4'hE, 1'b0, 4'h0));
    vecs.push_back(mk(23, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(27, 4'hC, 1'b0, 4'h0));
    vecs.push_back(mk(28, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(34, 4'h8, 1'b0, 4'h0));
    vecs.push_back(mk(35, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(37, 4'h0, 1'b0, 4'h0));
    vecs.push_back(mk(38, 4'h0, 1'b1, 4'h0));
    run_table("preack", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
